// File: rtl/macc_pkg.sv
// Shared constants and types for the windowed multiply-accumulate block.
// Build option: MACC_SAT_EN (see macc_sat) selects clamping of the result.
package macc_pkg;

    localparam int N_TAPS_DEF = 9;
    localparam int ACC_W_DEF  = 24;
    localparam int OUT_W_DEF  = 16;
    localparam int PROD_W     = 15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } macc_state_e;

endpackage

// File: rtl/macc_sat.sv
// Combinational reduction of the wide accumulator sum to the output width.
// Build option MACC_SAT_EN: defined -> clamp to the signed OUT_W range and flag it;
// undefined -> keep the low OUT_W bits (two's-complement wrap), flag tied low.
module macc_sat
    import macc_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic signed [ACC_W-1:0] i_sum,
    output logic        [OUT_W-1:0] o_res,
    output logic                    o_sat
);

`ifdef MACC_SAT_EN
    localparam logic signed [ACC_W-1:0] LP_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] LP_MIN = ~LP_MAX;

    // Clamp to the representable signed output range.
    always_comb begin
        o_res = i_sum[OUT_W-1:0];
        o_sat = 1'b0;
        if (i_sum > LP_MAX) begin
            o_res = LP_MAX[OUT_W-1:0];
            o_sat = 1'b1;
        end else if (i_sum < LP_MIN) begin
            o_res = LP_MIN[OUT_W-1:0];
            o_sat = 1'b1;
        end
    end
`else
    // Upper sum bits are intentionally dropped in the wrapping build.
    logic w_unused_hi;
    assign w_unused_hi = ^i_sum[ACC_W-1:OUT_W];
    assign o_res       = i_sum[OUT_W-1:0];
    assign o_sat       = 1'b0;
`endif

endmodule

// File: rtl/macc_accumulator.sv
// Window accumulator: sums N_TAPS signed products, then holds the reduced
// result until downstream accepts it. Build option MACC_SAT_EN (in macc_sat).
//
// state    | meaning
// ST_IDLE  | waiting for first product of a window
// ST_ACCUM | window partially summed, waiting for more products
// ST_HOLD  | result valid on o_acc/o_sat, waiting for i_ready
module macc_accumulator
    import macc_pkg::*;
#(
    parameter int N_TAPS = N_TAPS_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int OUT_W  = OUT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_valid,
    input  logic [PROD_W-1:0] i_mul,
    output logic              o_ready,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [OUT_W-1:0]  o_acc,
    output logic              o_sat
);

    localparam logic [7:0] LP_LAST = 8'(N_TAPS);

    macc_state_e             r_state;
    logic [7:0]              r_cnt;
    logic signed [ACC_W-1:0] r_acc;
    logic [OUT_W-1:0]        r_res;
    logic                    r_sat;

    logic                    w_beat;
    logic                    w_last;
    logic [7:0]              w_cnt_next;
    logic signed [ACC_W-1:0] w_mul_ext;
    logic signed [ACC_W-1:0] w_sum;
    logic [OUT_W-1:0]        w_res;
    logic                    w_sat;

    assign o_ready    = (r_state != ST_HOLD);
    assign o_valid    = (r_state == ST_HOLD);
    assign o_acc      = r_res;
    assign o_sat      = r_sat;

    assign w_beat     = i_valid & o_ready;
    assign w_mul_ext  = ACC_W'($signed(i_mul));
    // The first beat of a window loads rather than adds, so no separate clear is needed.
    assign w_sum      = (r_state == ST_IDLE) ? w_mul_ext : (r_acc + w_mul_ext);
    assign w_cnt_next = (r_state == ST_IDLE) ? 8'd1 : (r_cnt + 8'd1);
    assign w_last     = (w_cnt_next == LP_LAST);

    macc_sat #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W)
    ) u_sat (
        .i_sum (w_sum),
        .o_res (w_res),
        .o_sat (w_sat)
    );

    // Window FSM, tap counter, accumulator and registered result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_res   <= '0;
            r_sat   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_ACCUM: begin
                    if (i_clear) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                        r_acc   <= '0;
                    end else if (w_beat) begin
                        r_acc <= w_sum;
                        r_cnt <= w_cnt_next;
                        if (w_last) begin
                            r_state <= ST_HOLD;
                            r_res   <= w_res;
                            r_sat   <= w_sat;
                        end else begin
                            r_state <= ST_ACCUM;
                        end
                    end
                end
                ST_HOLD: begin
                    if (i_ready) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_macc_accumulator.sv
// Self-checking bench for macc_accumulator (default N_TAPS=9, OUT_W=16).
// Expected results come from summing each window's products as plain integers.
module tb_macc_accumulator;

    localparam int NT = 9;
    localparam int OW = 16;

    typedef int iq_t[$];

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_clear = 1'b0;
    logic          i_valid = 1'b0;
    logic [14:0]   i_mul = '0;
    logic          o_ready;
    logic          o_valid;
    logic          i_ready = 1'b0;
    logic [OW-1:0] o_acc;
    logic          o_sat;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [OW-1:0] last_res = '0;
    logic          last_sat = 1'b0;

    macc_accumulator #(.N_TAPS(NT), .ACC_W(24), .OUT_W(OW)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_clear (i_clear),
        .i_valid (i_valid),
        .i_mul   (i_mul),
        .o_ready (o_ready),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_acc   (o_acc),
        .o_sat   (o_sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic longint window_sum(input iq_t q);
        longint s = 0;
        foreach (q[i]) s += q[i];
        return s;
    endfunction

    function automatic logic [OW-1:0] model_acc(input iq_t q);
        longint s = window_sum(q);
`ifdef MACC_SAT_EN
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
`endif
        return OW'(s);
    endfunction

    function automatic logic model_sat(input iq_t q);
`ifdef MACC_SAT_EN
        longint s = window_sum(q);
        return (s > 32767) || (s < -32768);
`else
        return 1'b0;
`endif
    endfunction

    function automatic iq_t rep(input int v, input int n);
        iq_t q;
        for (int i = 0; i < n; i++) q.push_back(v);
        return q;
    endfunction

    function automatic int rand_prod();
        return int'($urandom_range(0, 32767)) - 16384;
    endfunction

    task automatic beat(input int v);
        i_valid = 1'b1;
        i_mul   = 15'(v);
        chk("ready_on_beat", 32'(o_ready), 32'd1);
        tick();
        i_valid = 1'b0;
        i_mul   = 15'($urandom);
    endtask

    // Feed one window with optional idle gaps, check the result, stall for
    // 'hold' cycles with garbage products and i_clear, then handshake.
    task automatic run_window(input string tag, input iq_t q, input int max_gap, input int hold);
        logic [OW-1:0] exp_acc;
        logic          exp_sat;
        exp_acc = model_acc(q);
        exp_sat = model_sat(q);
        foreach (q[i]) begin
            repeat ($urandom_range(0, max_gap)) begin
                tick();
                chk({tag, "_gap_valid"}, 32'(o_valid), 32'd0);
            end
            beat(q[i]);
            if (i != q.size() - 1) chk({tag, "_early_valid"}, 32'(o_valid), 32'd0);
        end
        chk({tag, "_valid"}, 32'(o_valid), 32'd1);
        chk({tag, "_acc"}, 32'(o_acc), 32'(exp_acc));
        chk({tag, "_sat"}, 32'(o_sat), 32'(exp_sat));
        chk({tag, "_hold_ready"}, 32'(o_ready), 32'd0);
        for (int k = 0; k < hold; k++) begin
            i_valid = 1'($urandom);
            i_mul   = 15'($urandom);
            i_clear = 1'($urandom);
            tick();
            chk({tag, "_stall_valid"}, 32'(o_valid), 32'd1);
            chk({tag, "_stall_ready"}, 32'(o_ready), 32'd0);
            chk({tag, "_stall_acc"}, 32'(o_acc), 32'(exp_acc));
        end
        i_valid = 1'b0;
        i_clear = 1'b0;
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        chk({tag, "_done_valid"}, 32'(o_valid), 32'd0);
        chk({tag, "_done_ready"}, 32'(o_ready), 32'd1);
        chk({tag, "_done_acc"}, 32'(o_acc), 32'(exp_acc));
        last_res = exp_acc;
        last_sat = exp_sat;
    endtask

    initial begin
        iq_t q;

        tick();
        tick();
        rst = 1'b0;
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_ready", 32'(o_ready), 32'd1);
        chk("rst_acc", 32'(o_acc), 32'd0);
        chk("rst_sat", 32'(o_sat), 32'd0);

        run_window("ones", rep(1, NT), 0, 0);
        run_window("p1400", rep(1400, NT), 1, 2);
        run_window("pmax", rep(16383, NT), 0, 1);
        run_window("pmin", rep(-16384, NT), 2, 0);
        run_window("stall5", rep(-3, NT), 0, 5);

        // Partial window aborted by reset.
        for (int i = 0; i < 4; i++) beat(7);
        rst = 1'b1;
        i_clear = 1'b1;
        i_valid = 1'b1;
        i_mul = 15'd7;
        tick();
        rst = 1'b0;
        i_clear = 1'b0;
        i_valid = 1'b0;
        chk("midrst_valid", 32'(o_valid), 32'd0);
        chk("midrst_ready", 32'(o_ready), 32'd1);
        chk("midrst_acc", 32'(o_acc), 32'd0);
        chk("midrst_sat", 32'(o_sat), 32'd0);
        run_window("after_rst", rep(2, NT), 0, 0);

        // Partial window aborted by i_clear together with a beat.
        for (int i = 0; i < 4; i++) beat(7);
        i_clear = 1'b1;
        i_valid = 1'b1;
        i_mul = 15'd7;
        tick();
        i_clear = 1'b0;
        i_valid = 1'b0;
        chk("clr_valid", 32'(o_valid), 32'd0);
        chk("clr_ready", 32'(o_ready), 32'd1);
        chk("clr_keep_acc", 32'(o_acc), 32'(last_res));
        chk("clr_keep_sat", 32'(o_sat), 32'(last_sat));
        run_window("after_clr", rep(2, NT), 1, 0);

        // Random windows, some biased to large magnitudes.
        for (int w = 0; w < 25; w++) begin
            q.delete();
            for (int i = 0; i < NT; i++) begin
                if (w % 3 == 0) q.push_back(($urandom_range(0, 1) != 0) ? 16383 - int'($urandom_range(0, 99))
                                                                       : -16384 + int'($urandom_range(0, 99)));
                else q.push_back(rand_prod());
            end
            run_window("rand", q, 2, int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
